// File: rtl/stq_violation_scanner_if.sv
// Handshake bundle between the STQ violation scanner, the following-load RAM and the LDQ probe port.
// Optional perf counter signals are present only when STQ_SCAN_PERF_EN is defined.
interface stq_violation_scanner_if #(
  parameter int LDQ_INDEX  = 4,
  parameter int STQ_INDEX  = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                  flush_i;
  logic                  stReq_i;
  logic                  stReady_o;
  logic [STQ_INDEX-1:0]  stIndex_i;
  logic [ADDR_WIDTH-1:0] stAddr_i;
  logic [LDQ_INDEX-1:0]  ldqTail_i;
  logic [STQ_INDEX-1:0]  followLdAddr_o;
  logic [LDQ_INDEX-1:0]  followLdData_i;
  logic [LDQ_INDEX-1:0]  ldProbeIdx_o;
  logic                  ldProbeValid_i;
  logic                  ldProbeExec_i;
  logic [ADDR_WIDTH-1:0] ldProbeAddr_i;
  logic                  done_o;
  logic                  viol_o;
  logic [LDQ_INDEX-1:0]  violLdIndex_o;
`ifdef STQ_SCAN_PERF_EN
  logic [31:0]           scanCycles_o;
  logic [15:0]           violCount_o;

  modport slave (
    input  flush_i, stReq_i, stIndex_i, stAddr_i, ldqTail_i, followLdData_i,
           ldProbeValid_i, ldProbeExec_i, ldProbeAddr_i,
    output stReady_o, followLdAddr_o, ldProbeIdx_o, done_o, viol_o, violLdIndex_o,
           scanCycles_o, violCount_o
  );
  modport master (
    output flush_i, stReq_i, stIndex_i, stAddr_i, ldqTail_i, followLdData_i,
           ldProbeValid_i, ldProbeExec_i, ldProbeAddr_i,
    input  stReady_o, followLdAddr_o, ldProbeIdx_o, done_o, viol_o, violLdIndex_o,
           scanCycles_o, violCount_o
  );
`else
  modport slave (
    input  flush_i, stReq_i, stIndex_i, stAddr_i, ldqTail_i, followLdData_i,
           ldProbeValid_i, ldProbeExec_i, ldProbeAddr_i,
    output stReady_o, followLdAddr_o, ldProbeIdx_o, done_o, viol_o, violLdIndex_o
  );
  modport master (
    output flush_i, stReq_i, stIndex_i, stAddr_i, ldqTail_i, followLdData_i,
           ldProbeValid_i, ldProbeExec_i, ldProbeAddr_i,
    input  stReady_o, followLdAddr_o, ldProbeIdx_o, done_o, viol_o, violLdIndex_o
  );
`endif
endinterface

// File: rtl/stq_violation_scanner.sv
// Walks the LDQ from a store's following-load index to the tail and reports the oldest executed
// younger load with the same word address. Define STQ_SCAN_PERF_EN to add scan/violation counters.
module stq_violation_scanner #(
  parameter int LDQ_DEPTH  = 16,
  parameter int LDQ_INDEX  = 4,
  parameter int STQ_INDEX  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input logic                     clk,
  input logic                     reset,
  stq_violation_scanner_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOOKUP, SCAN, DONE} state_t;

  if (LDQ_DEPTH != (1 << LDQ_INDEX)) begin : g_depth_chk
    $error("LDQ_DEPTH must equal 2**LDQ_INDEX");
  end

  state_t                  state;
  logic [ADDR_WIDTH-3:0]   st_word;
  logic [LDQ_INDEX-1:0]    end_idx;
  logic [LDQ_INDEX-1:0]    ptr_next;
  logic                    match;
  logic                    unused_lsbs;

  assign unused_lsbs   = ^{bus.stAddr_i[1:0], bus.ldProbeAddr_i[1:0]};
  assign bus.stReady_o = (state == IDLE) & ~bus.flush_i;
  assign ptr_next      = bus.ldProbeIdx_o + LDQ_INDEX'(1);
  assign match         = bus.ldProbeValid_i & bus.ldProbeExec_i &
                         (bus.ldProbeAddr_i[ADDR_WIDTH-1:2] == st_word);

  // Store word and scan end are pure data: captured without reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.stReq_i && !bus.flush_i)
      st_word <= bus.stAddr_i[ADDR_WIDTH-1:2];
    if (state == LOOKUP)
      end_idx <= bus.ldqTail_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      bus.followLdAddr_o <= '0;
      bus.ldProbeIdx_o   <= '0;
      bus.done_o         <= 1'b0;
      bus.viol_o         <= 1'b0;
      bus.violLdIndex_o  <= '0;
    end else begin
      bus.done_o        <= 1'b0;
      bus.viol_o        <= 1'b0;
      bus.violLdIndex_o <= '0;
      if (bus.flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.stReq_i) begin
              bus.followLdAddr_o <= bus.stIndex_i;
              state              <= LOOKUP;
            end
          end
          LOOKUP: begin
            if (bus.followLdData_i == bus.ldqTail_i) begin
              bus.done_o <= 1'b1;
              state      <= DONE;
            end else begin
              bus.ldProbeIdx_o <= bus.followLdData_i;
              state            <= SCAN;
            end
          end
          SCAN: begin
            // First hit wins: the walk runs oldest to youngest.
            if (match) begin
              bus.done_o        <= 1'b1;
              bus.viol_o        <= 1'b1;
              bus.violLdIndex_o <= bus.ldProbeIdx_o;
              state             <= DONE;
            end else if (ptr_next == end_idx) begin
              bus.done_o <= 1'b1;
              state      <= DONE;
            end else begin
              bus.ldProbeIdx_o <= ptr_next;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef STQ_SCAN_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.scanCycles_o <= '0;
      bus.violCount_o  <= '0;
    end else begin
      if (state == SCAN && !(&bus.scanCycles_o))
        bus.scanCycles_o <= bus.scanCycles_o + 32'd1;
      if (bus.done_o && bus.viol_o && !(&bus.violCount_o))
        bus.violCount_o <= bus.violCount_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stq_violation_scanner.sv
// Directed table-driven bench for stq_violation_scanner, plus flush and reset corner sequences.
module tb_stq_violation_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stq_violation_scanner_if #(.LDQ_INDEX(4), .STQ_INDEX(4), .ADDR_WIDTH(32)) bus ();

  stq_violation_scanner #(.LDQ_DEPTH(16), .LDQ_INDEX(4), .STQ_INDEX(4), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [3:0]  follow_ram [16];
  logic [31:0] ld_addr    [16];
  logic [15:0] valid_mask;
  logic [15:0] exec_mask;

  assign bus.followLdData_i = follow_ram[bus.followLdAddr_o];
  assign bus.ldProbeValid_i = valid_mask[bus.ldProbeIdx_o];
  assign bus.ldProbeExec_i  = exec_mask[bus.ldProbeIdx_o];
  assign bus.ldProbeAddr_i  = ld_addr[bus.ldProbeIdx_o];

  typedef struct {
    logic [3:0]  st_idx;
    logic [31:0] st_addr;
    logic [3:0]  follow;
    logic [3:0]  tail;
    logic [15:0] valid;
    logic [15:0] exec;
    logic [15:0] match;
    int          exp_done;
    logic        exp_viol;
    logic [3:0]  exp_idx;
  } vec_t;

  vec_t vecs [7];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 16; i++) begin
      follow_ram[i] = 4'd0;
      ld_addr[i]    = v.match[i] ? {v.st_addr[31:2], 2'b00} : v.st_addr + 32'h4;
    end
    follow_ram[v.st_idx] = v.follow;
    valid_mask           = v.valid;
    exec_mask            = v.exec;
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    check("ready_before_req", bus.stReady_o, 1);
    bus.stReq_i   = 1'b1;
    bus.stIndex_i = v.st_idx;
    bus.stAddr_i  = v.st_addr;
    bus.ldqTail_i = v.tail;
  endtask

  task automatic run_vec(input int n);
    vec_t       v;
    int         done_c, nprobe, act_viol, act_idx;
    bit         seq_ok, busy_ok, moved;
    logic [3:0] pre, exp_p;
    v = vecs[n];
    load_vec(v);
    pre = bus.ldProbeIdx_o;
    issue(v);
    done_c = -1; nprobe = 0; seq_ok = 1; busy_ok = 1; moved = 0;
    act_viol = 0; act_idx = 0;
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      @(negedge clk);
      if (bus.stReady_o) busy_ok = 0;
      if (bus.ldProbeIdx_o != pre) moved = 1;
      if (bus.done_o) begin
        done_c   = c;
        act_viol = bus.viol_o;
        act_idx  = bus.violLdIndex_o;
      end else if (c >= 2) begin
        exp_p = v.follow + nprobe[3:0];
        if (bus.ldProbeIdx_o != exp_p) seq_ok = 0;
        nprobe++;
      end
      if (c == 1) bus.stReq_i = 1'b0;
    end
    bus.stReq_i = 1'b0;
    check($sformatf("v%0d_done_cycle", n), done_c, v.exp_done);
    check($sformatf("v%0d_viol", n), act_viol, v.exp_viol);
    check($sformatf("v%0d_viol_idx", n), act_idx, v.exp_idx);
    check($sformatf("v%0d_probe_count", n), nprobe, v.exp_done - 2);
    check($sformatf("v%0d_probe_order", n), seq_ok, 1);
    check($sformatf("v%0d_busy_not_ready", n), busy_ok, 1);
    if (v.exp_done == 2) check($sformatf("v%0d_no_probe_activity", n), moved, 0);
    @(negedge clk);
    check($sformatf("v%0d_done_single_pulse", n), bus.done_o, 0);
    check($sformatf("v%0d_ready_after_done", n), bus.stReady_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    //        st    addr          fol    tail   valid     exec      match     done viol idx
    vecs[0] = '{4'd1, 32'h100,      4'd3,  4'd3,  16'hFFFF, 16'h0000, 16'h0000, 2,   1'b0, 4'd0};
    vecs[1] = '{4'd2, 32'h102,      4'd2,  4'd6,  16'hFFFF, 16'h0030, 16'h0020, 6,   1'b1, 4'd5};
    vecs[2] = '{4'd3, 32'h200,      4'd14, 4'd2,  16'hFFFF, 16'h0002, 16'h0002, 6,   1'b1, 4'd1};
    vecs[3] = '{4'd4, 32'h300,      4'd3,  4'd10, 16'hFFFF, 16'hFFFF, 16'h0088, 3,   1'b1, 4'd3};
    vecs[4] = '{4'd5, 32'h400,      4'd8,  4'd12, 16'hFFFF, 16'h0000, 16'hFFFF, 6,   1'b0, 4'd0};
    vecs[5] = '{4'd6, 32'h500,      4'd5,  4'd4,  16'hFFFF, 16'hFFFF, 16'h0000, 17,  1'b0, 4'd0};
    vecs[6] = '{4'd7, 32'h600,      4'd10, 4'd13, 16'h1000, 16'hFFFF, 16'hFFFF, 5,   1'b1, 4'd12};

    bus.flush_i = 1'b0; bus.stReq_i = 1'b0; bus.stIndex_i = '0;
    bus.stAddr_i = '0; bus.ldqTail_i = '0;
    load_vec(vecs[0]);
    repeat (2) @(negedge clk);
    check("rst_ready", bus.stReady_o, 1);
    check("rst_done", bus.done_o, 0);
    check("rst_viol", bus.viol_o, 0);
    check("rst_viol_idx", bus.violLdIndex_o, 0);
    check("rst_follow_addr", bus.followLdAddr_o, 0);
    check("rst_probe_idx", bus.ldProbeIdx_o, 0);
    reset = 1'b0;

    for (int n = 0; n < 7; n++) run_vec(n);

    // Flush while idle blocks acceptance of a simultaneous request.
    @(negedge clk);
    bus.flush_i = 1'b1; bus.stReq_i = 1'b1;
    #1 check("flush_idle_not_ready", bus.stReady_o, 0);
    @(negedge clk);
    bus.flush_i = 1'b0; bus.stReq_i = 1'b0;
    #1 check("flush_idle_req_dropped", bus.stReady_o, 1);

    // Flush in cycle 3 of a long scan.
    load_vec(vecs[5]);
    issue(vecs[5]);
    @(negedge clk); bus.stReq_i = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.flush_i = 1'b1;
    @(negedge clk); bus.flush_i = 1'b0;
    #1 check("flush_scan_ready_next", bus.stReady_o, 1);
    begin
      int dones = bus.done_o;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        dones += bus.done_o;
      end
      check("flush_scan_no_done", dones, 0);
    end
    run_vec(1);

    // Asynchronous reset in the middle of a scan.
    load_vec(vecs[5]);
    issue(vecs[5]);
    @(negedge clk); bus.stReq_i = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #1 check("rst_scan_probe_idx", bus.ldProbeIdx_o, 0);
    check("rst_scan_done", bus.done_o, 0);
    @(negedge clk); reset = 1'b0;
    #1 check("rst_scan_ready", bus.stReady_o, 1);
    begin
      int dones = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        dones += bus.done_o;
      end
      check("rst_scan_no_done", dones, 0);
    end
    run_vec(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
